// File: rtl/fetch_unit.sv
// fetch_unit -- instruction-fetch stage in front of a 64 x 30-bit instruction memory
// whose read data is registered (data appears the cycle after the address).
//
// The unit owns the program counter and streams {pc, instruction} pairs to
// decode. A 2-entry skid FIFO absorbs the one-cycle read latency, so decode
// can take one instruction per cycle. A branch redirect flushes the FIFO and
// squashes the read that is in flight.
//
// Ports:
//   clk           system clock, all state updates on the rising edge
//   rst           synchronous, active-high reset
//   mem_fetch_en  memory read enable, constant 1 (the memory writes when it is 0)
//   mem_pc        memory address, equal to the internal next-fetch pc
//   mem_instr     memory read data for the address issued on the previous cycle
//   br_valid      single-cycle redirect request
//   br_target     redirect address
//   out_valid     a {pc, instruction} pair is offered to decode
//   out_ready     decode accepts the offered pair
//   out_instr     offered instruction
//   out_pc        address the offered instruction was read from
//
// Decode handshake: a transfer happens on every rising edge where out_valid and
// out_ready are both 1. out_valid never depends combinationally on out_ready, and
// while out_valid=1 and out_ready=0 the values on out_pc/out_instr do not change.
// A redirect is the one exception: it drops out_valid without a transfer.
// A transfer on the same edge as a redirect counts as accepted by decode.

module fetch_unit #(
   parameter int PC_W     = 6,
   parameter int INSTR_W  = 30,
   parameter int RESET_PC = 0
) (
   input  logic               clk,
   input  logic               rst,
   output logic               mem_fetch_en,
   output logic [PC_W-1:0]    mem_pc,
   input  logic [INSTR_W-1:0] mem_instr,
   input  logic               br_valid,
   input  logic [PC_W-1:0]    br_target,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INSTR_W-1:0] out_instr,
   output logic [PC_W-1:0]    out_pc
);

   localparam logic [PC_W-1:0] RESET_PC_V = PC_W'(RESET_PC);

   // Next address to fetch.
   logic [PC_W-1:0]    pc_q;
   // A read was issued last cycle. Its data is on mem_instr this cycle.
   logic               inflight_q;
   logic [PC_W-1:0]    inflight_pc_q;

   // Skid FIFO storage. The head entry drives the decode outputs directly.
   logic [PC_W-1:0]    fifo_pc_q    [2];
   logic [INSTR_W-1:0] fifo_instr_q [2];
   logic               rd_ptr_q;
   logic               wr_ptr_q;
   logic [1:0]         count_q;

   logic               pop;
   logic               push;
   logic               issue;
   logic [2:0]         occupancy;

   // Idle cycles re-read mem_pc and discard the result. Tying the enable high
   // keeps the memory from ever taking a write.
   assign mem_fetch_en = 1'b1;
   assign mem_pc       = pc_q;

   assign out_valid = (count_q != 2'd0);
   assign out_pc    = fifo_pc_q[rd_ptr_q];
   assign out_instr = fifo_instr_q[rd_ptr_q];

   always_comb begin
      pop  = out_valid & out_ready;
      // A redirect squashes the read that is in flight, so its data is never captured.
      push = inflight_q & ~br_valid;
      // Slots committed after this edge: entries that stay, plus the entry arriving
      // from the in-flight read. A new read may only be issued when a slot is free
      // for its data. This keeps count + inflight <= 2, so the FIFO cannot overflow.
      occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
      issue     = ~rst & ~br_valid & (occupancy < 3'd2);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q          <= RESET_PC_V;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
         count_q       <= 2'd0;
         rd_ptr_q      <= 1'b0;
         wr_ptr_q      <= 1'b0;
         // Storage is cleared so out_pc/out_instr read 0 after reset.
         for (int i = 0; i < 2; i++) begin
            fifo_pc_q[i]    <= '0;
            fifo_instr_q[i] <= '0;
         end
      end else if (br_valid) begin
         // Flush the FIFO and drop the in-flight read. The target is issued next cycle.
         pc_q       <= br_target;
         inflight_q <= 1'b0;
         count_q    <= 2'd0;
         rd_ptr_q   <= 1'b0;
         wr_ptr_q   <= 1'b0;
      end else begin
         inflight_q <= issue;
         if (issue) begin
            inflight_pc_q <= pc_q;
            pc_q          <= pc_q + PC_W'(1);
         end
         if (push) begin
            fifo_pc_q[wr_ptr_q]    <= inflight_pc_q;
            fifo_instr_q[wr_ptr_q] <= mem_instr;
            wr_ptr_q               <= ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + 2'd1;
            2'b01:   count_q <= count_q - 2'd1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule
